iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//   Parametrised multi-cycle shifter. Generalises the fixed 1-bit logical left/right shift cells.
//   Takes a WIDTH-bit operand, a shift amount and a mode (SLL/SRL/SRA/ROR).
//   Shifts by up to STEP bits per clock; valid/ready handshake on both sides.
//   Sits beside the ALU and serves the shift-class instructions when a full barrel shifter is too costly.
// PARAMETERS
//   WIDTH    32                   operand/result width in bits; >= 2
//   STEP     1                    max bits shifted per cycle; power of 2, 1..WIDTH
//   SHAMT_W  $clog2(WIDTH)        localparam; width of the shift amount
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst_n      in   1        synchronous active-low reset
//   in_valid   in   1        request valid
//   in_ready   out  1        block can accept a request (= state==IDLE)
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//   in_op      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
//   out_valid  out  1        result valid; held until accepted
//   out_ready  in   1        consumer accepts result
//   out_data   out  WIDTH    result; stable while out_valid=1
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_data=0, internal remaining count=0.
//   Reset mid-operation aborts the job; the partial result is dropped and no out_valid is issued.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: in_ready=1. If in_valid, latch in_data, in_shamt and in_op.
//     -> SHIFT if in_shamt!=0; -> DONE if in_shamt==0 (result = in_data unchanged).
//   SHIFT: in_ready=0. Each cycle:
//     - k = min(STEP, remaining); shift the working value by k per op; remaining -= k.
//     - -> DONE when remaining becomes 0.
//   DONE: out_valid=1, out_data=working value. If out_ready -> IDLE (out_valid=0 next cycle).
//   Latency, accept edge to out_valid=1: 1 + ceil(shamt/STEP) cycles; shamt=0 gives 1 cycle.
//   No overlap: a new request is accepted only in IDLE. A request presented in the cycle
//     after a DONE handshake is accepted, giving a 1-cycle bubble.
//   Shift rules:
//     - SLL: zero-fill at LSB.  SRL: zero-fill at MSB.
//     - SRA: fill with the MSB of the working value, i.e. the original sign.
//     - ROR: bits leaving LSB re-enter at MSB.
//   in_shamt is limited to WIDTH-1 by its width; no overflow case exists.
//   STEP=WIDTH degenerates to a single-cycle SHIFT state: 2-cycle total latency.
//   out_ready asserted while out_valid=0 is ignored.
//   in_valid asserted while in_ready=0 is ignored; the requester holds the request.
//   The working value and count registers update only in SHIFT and on the IDLE accept.
// STRUCTURE
//   shift_defs.vh (shared include):
//     - op codes SH_SLL/SH_SRL/SH_SRA/SH_ROR
//     - FSM state encodings
//     - reused by the ALU decoder.
//   Sub-module shift_step:
//     - combinational; shifts a WIDTH value by amount k (0..STEP) per op code.
//     - one instance per iter_shifter; replaces the fixed 1-bit shift cells.
//   iter_shifter holds the FSM, the working register, the remaining counter and the output register.
// TESTING
//   (WIDTH=32 unless noted)
//   1. STEP=1, SLL, data=0x0000_0001, shamt=31
//      -> out_data=0x8000_0000; out_valid 32 cycles after accept.
//   2. STEP=4, SRA, data=0x8000_00F0, shamt=5
//      -> out_data=0xFC00_0007 after 1+2=3 cycles; second step shifts 1 bit, not 4.
//   3. STEP=1, ROR, data=0x0000_0003, shamt=1 -> out_data=0x8000_0001;
//      SRL with the same operands -> 0x0000_0001.
//   4. shamt=0, SRL, data=0xDEAD_BEEF
//      -> out_data=0xDEAD_BEEF, out_valid on the cycle after accept; in_ready=0 meanwhile.
//   5. Backpressure: hold out_ready=0 for 5 cycles after out_valid
//      -> out_valid/out_data stable and in_ready=0 throughout; IDLE one cycle after out_ready=1.
//   6. Drop rst_n for one edge mid-SHIFT (STEP=1, shamt=20, after 8 cycles)
//      -> next cycle out_valid=0, out_data=0, in_ready=1; the next request completes correctly.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter and its step cell.
//   shift_op_e    : operation codes as presented on in_op (also reused by the ALU decoder)
//   shift_state_e : control FSM state encodings
package iter_shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,   // logical left, zero fill at LSB
        SH_SRL = 2'b01,   // logical right, zero fill at MSB
        SH_SRA = 2'b10,   // arithmetic right, sign fill
        SH_ROR = 2'b11    // rotate right
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational shift of a WIDTH-bit value by a small amount.
//   op   in  shift operation (SLL/SRL/SRA/ROR)
//   din  in  value to shift
//   amt  in  shift amount, 0..STEP (never reaches WIDTH)
//   dout out shifted value
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  shift_op_e          op,
    input  logic [WIDTH-1:0]   din,
    input  logic [AMT_W-1:0]   amt,
    output logic [WIDTH-1:0]   dout
);

    // Left-shift distance for the rotate's wrapped part. With amt=0 this is
    // WIDTH, which shifts everything out and leaves din unchanged.
    logic [AMT_W:0] wrap_amt;

    always_comb begin
        wrap_amt = (AMT_W+1)'(WIDTH) - {1'b0, amt};
        dout     = din;
        case (op)
            SH_SLL:  dout = din << amt;
            SH_SRL:  dout = din >> amt;
            SH_SRA:  dout = $signed(din) >>> amt;
            SH_ROR:  dout = (din >> amt) | (din << wrap_amt);
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter shifting up to STEP bits per clock.
//   clk       in   clock, all state updates on rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   request valid
//   in_ready  out  request accepted when high (FSM idle)
//   in_data   in   operand
//   in_shamt  in   shift amount 0..WIDTH-1
//   in_op     in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid out  result valid, held until out_ready
//   out_ready in   consumer accepts result
//   out_data  out  result, stable while out_valid is high
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    // One extra bit so that STEP=WIDTH is representable in the step amount.
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    shift_state_e        state, state_nxt;
    shift_op_e           op_q;
    logic [WIDTH-1:0]    work;
    logic [SHAMT_W-1:0]  remaining;

    logic [CNT_W-1:0]    rem_ext;
    logic [CNT_W-1:0]    k;
    logic [SHAMT_W-1:0]  rem_nxt;
    logic [WIDTH-1:0]    step_out;

    // k = min(STEP, remaining); k <= remaining < WIDTH so its low bits
    // are enough for the counter update.
    always_comb begin
        rem_ext = {1'b0, remaining};
        k       = (rem_ext < STEP_C) ? rem_ext : STEP_C;
        rem_nxt = remaining - k[SHAMT_W-1:0];
    end

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (CNT_W)
    ) u_step (
        .op   (op_q),
        .din  (work),
        .amt  (k),
        .dout (step_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (rem_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Datapath: working value, remaining count, result register.
    // The result register is loaded on the same edge that enters DONE,
    // so out_data is already valid in the first DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work      <= '0;
            remaining <= '0;
            op_q      <= SH_SLL;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work      <= in_data;
                        remaining <= in_shamt;
                        op_q      <= shift_op_e'(in_op);
                        if (in_shamt == '0) out_data <= in_data;
                    end
                end
                ST_SHIFT: begin
                    work      <= step_out;
                    remaining <= rem_nxt;
                    if (rem_nxt == '0) out_data <= step_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: four instances (STEP 1, 2, 4, 32),
// directed vector table, backpressure and mid-shift reset sequences, and
// randomized requests checked against an arithmetic reference model.
module tb_iter_shifter;

    localparam int N = 4;

    logic        clk;
    logic        rst_n     [N];
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [31:0] in_data   [N];
    logic [4:0]  in_shamt  [N];
    logic [1:0]  in_op     [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] out_data  [N];

    int checks = 0;
    int errors = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        iter_shifter #(
            .WIDTH (32),
            .STEP  (g == 3 ? 32 : (1 << g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_shamt  (in_shamt[g]),
            .in_op     (in_op[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    function automatic int step_of(input int idx);
        return (idx == 3) ? 32 : (1 << idx);
    endfunction

    // Reference model: shift rules expressed with plain arithmetic.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
        logic [63:0] w;
        case (op)
            2'b00: begin w = {32'h0, d} << s; return w[31:0]; end
            2'b01: return d >> s;
            2'b10: return d[31] ? ~((~d) >> s) : (d >> s);
            default: begin w = {d, d} >> s; return w[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input int s, input int step);
        return 1 + (s + step - 1) / step;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request on instance idx, wait for the result, then accept it.
    task automatic run(input int idx, input logic [31:0] d, input int s, input logic [1:0] op,
                       output logic [31:0] res, output int lat);
        int busy;
        chk("idle_in_ready", in_ready[idx], 1);
        in_data[idx]  = d;
        in_shamt[idx] = 5'(s);
        in_op[idx]    = op;
        in_valid[idx] = 1;
        @(posedge clk); #1;
        in_valid[idx] = 0;
        in_data[idx]  = $urandom;
        lat  = 1;
        busy = 0;
        while (!out_valid[idx] && lat < 100) begin
            if (in_ready[idx]) busy++;
            out_ready[idx] = 1'($urandom_range(0, 1));   // ignored while out_valid=0
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready[idx]) busy++;
        chk("busy_in_ready_low", 64'(busy), 0);
        res = out_data[idx];
        out_ready[idx] = 1;
        @(posedge clk); #1;
        out_ready[idx] = 0;
        chk("post_ack_out_valid", out_valid[idx], 0);
        chk("post_ack_in_ready", in_ready[idx], 1);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] d;
        int          s;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs [9];
        logic [31:0] res;
        int          lat;

        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        int          cnt;

        vecs[0] = '{0, 32'h0000_0001, 31, 2'b00, 32'h8000_0000, 32};
        vecs[1] = '{2, 32'h8000_00F0,  5, 2'b10, 32'hFC00_0007,  3};
        vecs[2] = '{0, 32'h0000_0003,  1, 2'b11, 32'h8000_0001,  2};
        vecs[3] = '{0, 32'h0000_0003,  1, 2'b01, 32'h0000_0001,  2};
        vecs[4] = '{0, 32'hDEAD_BEEF,  0, 2'b01, 32'hDEAD_BEEF,  1};
        vecs[5] = '{3, 32'h0000_0001, 31, 2'b00, 32'h8000_0000,  2};
        vecs[6] = '{1, 32'h1234_5678,  8, 2'b11, 32'h7812_3456,  5};
        vecs[7] = '{2, 32'hF000_0000,  4, 2'b01, 32'h0F00_0000,  2};
        vecs[8] = '{3, 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF,  2};

        for (int i = 0; i < N; i++) begin
            rst_n[i] = 0; in_valid[i] = 0; in_data[i] = '0;
            in_shamt[i] = '0; in_op[i] = '0; out_ready[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rst_n[i] = 1;
        for (int i = 0; i < N; i++) begin
            chk("reset_out_valid", out_valid[i], 0);
            chk("reset_out_data", out_data[i], 0);
            chk("reset_in_ready", in_ready[i], 1);
        end

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run(vecs[i].idx, vecs[i].d, vecs[i].s, vecs[i].op, res, lat);
            chk("vec_data", res, vecs[i].exp);
            chk("vec_latency", 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure on STEP=2: result must hold, a competing request must wait.
        in_data[1] = 32'hA5A5_A5A5; in_shamt[1] = 5'd6; in_op[1] = 2'b01; in_valid[1] = 1;
        @(posedge clk); #1;
        in_valid[1] = 0;
        cnt = 0;
        while (!out_valid[1] && cnt < 100) begin @(posedge clk); #1; cnt++; end
        chk("bp_reached_done", out_valid[1], 1);
        held = out_data[1];
        chk("bp_data", held, 32'h0296_9696);
        in_data[1] = 32'h1111_1111; in_shamt[1] = 5'd3; in_op[1] = 2'b00; in_valid[1] = 1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", out_valid[1], 1);
            chk("bp_out_data_stable", out_data[1], held);
            chk("bp_in_ready_low", in_ready[1], 0);
        end
        out_ready[1] = 1;
        @(posedge clk); #1;
        out_ready[1] = 0;
        chk("bp_ack_out_valid", out_valid[1], 0);
        chk("bp_ack_in_ready", in_ready[1], 1);
        // Held request accepted on this edge (one-cycle bubble).
        @(posedge clk); #1;
        in_valid[1] = 0;
        lat = 1;
        while (!out_valid[1] && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("bubble_data", out_data[1], 32'h8888_8888);
        chk("bubble_latency", 64'(lat), 3);
        out_ready[1] = 1;
        @(posedge clk); #1;
        out_ready[1] = 0;

        // Reset mid-shift on STEP=1.
        in_data[0] = 32'h0000_0001; in_shamt[0] = 5'd20; in_op[0] = 2'b00; in_valid[0] = 1;
        @(posedge clk); #1;
        in_valid[0] = 0;
        repeat (8) @(posedge clk);
        #1;
        rst_n[0] = 0;
        @(posedge clk); #1;
        rst_n[0] = 1;
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_in_ready", in_ready[0], 1);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid[0]) cnt++;
        end
        chk("midrst_no_result", 64'(cnt), 0);
        run(0, 32'h0000_000F, 4, 2'b00, res, lat);
        chk("midrst_next_data", res, 32'h0000_00F0);
        chk("midrst_next_latency", 64'(lat), 5);

        // Randomized requests against the reference model.
        for (int r = 0; r < 40; r++) begin
            int          idx;
            int          s;
            logic [31:0] d;
            logic [1:0]  op;
            idx = $urandom_range(0, N - 1);
            s   = $urandom_range(0, 31);
            d   = $urandom;
            op  = 2'($urandom_range(0, 3));
            run(idx, d, s, op, res, lat);
            chk("rand_data", res, ref_shift(d, s, op));
            chk("rand_latency", 64'(lat), 64'(ref_lat(s, step_of(idx))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
